// File: rtl/bf16_adder_arbiter.sv
// Round-robin share of one bf16 adder: registered operands, result delay line, response FIFO.
// Optional statistics counters are enabled with BF16_ARB_STATS_EN.
module bf16_adder_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADD_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*16-1:0]      req_a,
    input  logic [NUM_REQ*16-1:0]      req_b,
    output logic [15:0]                add_a,
    output logic [15:0]                add_b,
    input  logic [15:0]                add_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [15:0]                rsp_data
`ifdef BF16_ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [15:0]                stat_grants,
    output logic [15:0]                stat_stalls
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    logic            en_q;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic            can_issue;
    logic            gnt_hit;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   idx_w;
    logic            xfer;
    logic [15:0]     sel_a, sel_b;

    logic [15:0]     add_a_q, add_b_q;
    logic [ID_W-1:0] op_id_q;
    logic            op_vld_q;

    logic            dly_vld_q [ADD_LAT];
    logic [15:0]     dly_dat_q [ADD_LAT];
    logic [ID_W-1:0] dly_id_q  [ADD_LAT];

    logic [15:0]     fdat_q [FIFO_DEPTH];
    logic [ID_W-1:0] fid_q  [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic            push, pop;

    assign can_issue = (credit_q < CW'(FIFO_DEPTH));

    // Search order starts at the RR pointer and wraps modulo NUM_REQ
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        idx_w   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_q} + (ID_W+1)'(k);
            if (idx_w >= (ID_W+1)'(NUM_REQ)) begin
                idx_w = idx_w - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_hit && req_valid[idx_w[ID_W-1:0]]) begin
                gnt_hit = 1'b1;
                gnt_idx = idx_w[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (en_q && gnt_hit && can_issue) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |req_ready;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                sel_a = req_a[16*k +: 16];
                sel_b = req_b[16*k +: 16];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (xfer) begin
            rr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_comb begin
        credit_d = credit_q;
        if (xfer && !pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!xfer && pop) begin
            credit_d = credit_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            rr_q     <= '0;
            credit_q <= '0;
            op_vld_q <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            op_id_q  <= '0;
        end else begin
            en_q     <= 1'b1;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            op_vld_q <= xfer;
            if (xfer) begin
                add_a_q <= sel_a;
                add_b_q <= sel_b;
                op_id_q <= gnt_idx;
            end
        end
    end

    assign add_a = add_a_q;
    assign add_b = add_b_q;

    // Never stalls: credits reserve a FIFO slot for every issued op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < ADD_LAT; s++) begin
                dly_vld_q[s] <= 1'b0;
                dly_dat_q[s] <= '0;
                dly_id_q[s]  <= '0;
            end
        end else begin
            dly_vld_q[0] <= op_vld_q;
            if (op_vld_q) begin
                dly_dat_q[0] <= add_c;
                dly_id_q[0]  <= op_id_q;
            end
            for (int s = 1; s < ADD_LAT; s++) begin
                dly_vld_q[s] <= dly_vld_q[s-1];
                dly_dat_q[s] <= dly_dat_q[s-1];
                dly_id_q[s]  <= dly_id_q[s-1];
            end
        end
    end

    assign push = dly_vld_q[ADD_LAT-1];
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fdat_q[wr_q] <= dly_dat_q[ADD_LAT-1];
            fid_q[wr_q]  <= dly_id_q[ADD_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= (wr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign rsp_valid = (cnt_q != '0);
    assign rsp_data  = rsp_valid ? fdat_q[rd_q] : '0;
    assign rsp_id    = rsp_valid ? fid_q[rd_q] : '0;

`ifdef BF16_ARB_STATS_EN
    logic [15:0] gcnt_q [NUM_REQ];
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                gcnt_q[k] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_ready[k] && req_valid[k] && gcnt_q[k] != 16'hFFFF) begin
                    gcnt_q[k] <= gcnt_q[k] + 16'd1;
                end
            end
            if (|req_valid && !can_issue && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign stat_grants = gcnt_q[stat_sel];
    assign stat_stalls = stall_q;
`endif

endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// Directed bench for bf16_adder_arbiter; a real-valued bf16 adder stands in for bfloat_adder.
// Stats checks run only when BF16_ARB_STATS_EN is defined.
module tb_bf16_adder_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic [15:0] add_a, add_b, add_c;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
`ifdef BF16_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_grants, stat_stalls;
`endif

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] rr_b   [4] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
    logic [15:0] rr_sum [4] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0};

    always #5 clk = ~clk;

    function automatic real bf2r(input logic [15:0] x);
        if (x[14:7] == 8'd0) return 0.0;
        return $bitstoreal({x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0});
    endfunction

    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        real s;
        logic [63:0] d;
        s = bf2r(a) + bf2r(b);
        if (s == 0.0) return 16'h0000;
        d = $realtobits(s);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:45]};
    endfunction

    assign add_c = bf_add(add_a, add_b);

    bf16_adder_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef BF16_ARB_STATS_EN
        ,
        .stat_sel    (stat_sel),
        .stat_grants (stat_grants),
        .stat_stalls (stat_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef BF16_ARB_STATS_EN
        stat_sel  = 2'd0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_add_a", 32'(add_a), 32'h0);
        check("rst_add_b", 32'(add_b), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        req_valid = '0;
        rst = 1'b0;
        tick();
        tick();

        // single op
        req_a[15:0] = 16'h4218;
        req_b[15:0] = 16'h4150;
        rsp_ready   = 1'b1;
        req_valid   = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("single_add_a", 32'(add_a), 32'h4218);
        check("single_add_b", 32'(add_b), 32'h4150);
        check("single_c1", 32'(rsp_valid), 32'h0);
        tick();
        check("single_c2", 32'(rsp_valid), 32'h0);
        tick();
        check("single_c3_vld", 32'(rsp_valid), 32'h1);
        check("single_c3_id", 32'(rsp_id), 32'h0);
        check("single_c3_data", 32'(rsp_data), 32'h424C);
        tick();
        check("single_c4", 32'(rsp_valid), 32'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // round robin, all requesters active
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'h3F80;
            req_b[16*i +: 16] = rr_b[i];
        end
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            check($sformatf("rr_ready_%0d", k), 32'(req_ready),
                  (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
            if (k >= 3) begin
                check($sformatf("rr_vld_%0d", k), 32'(rsp_valid), 32'h1);
                check($sformatf("rr_id_%0d", k), 32'(rsp_id), 32'((k - 3) % 4));
                check($sformatf("rr_data_%0d", k), 32'(rsp_data), 32'(rr_sum[(k - 3) % 4]));
            end
            tick();
        end
        check("rr_empty", 32'(rsp_valid), 32'h0);

        // backpressure: four credits then stall
        req_a[31:16] = 16'h3F80;
        req_b[31:16] = 16'h3F80;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("bp_ready_%0d", k), 32'(req_ready), (k < 4) ? 32'h2 : 32'h0);
            tick();
        end
        check("bp_full_vld", 32'(rsp_valid), 32'h1);

        // drain while streaming: full FIFO popped with a new transfer in flight
        rsp_ready    = 1'b1;
        req_b[31:16] = 16'h4000;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("dr_ready_%0d", k), 32'(req_ready), (k == 0) ? 32'h0 : 32'h2);
            check($sformatf("dr_vld_%0d", k), 32'(rsp_valid), 32'h1);
            check($sformatf("dr_id_%0d", k), 32'(rsp_id), 32'h1);
            check($sformatf("dr_data_%0d", k), 32'(rsp_data), (k < 4) ? 32'h4000 : 32'h4040);
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("dr_tail_vld_%0d", k), 32'(rsp_valid), 32'h1);
            check($sformatf("dr_tail_data_%0d", k), 32'(rsp_data), 32'h4040);
            tick();
        end
        check("dr_empty", 32'(rsp_valid), 32'h0);

        // reset with two ops in flight
        req_a[15:0] = 16'h3F80;
        req_b[15:0] = 16'h3F80;
        req_valid   = 4'b0001;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rm_ready", 32'(req_ready), 32'h0);
        check("rm_add_a", 32'(add_a), 32'h0);
        check("rm_add_b", 32'(add_b), 32'h0);
        check("rm_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        tick();
        req_valid = 4'b1111;
        #1;
        check("rm_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("rm_c1", 32'(rsp_valid), 32'h0);
        tick();
        check("rm_c2", 32'(rsp_valid), 32'h0);
        tick();
        check("rm_c3_vld", 32'(rsp_valid), 32'h1);
        check("rm_c3_id", 32'(rsp_id), 32'h0);
        check("rm_c3_data", 32'(rsp_data), 32'h4000);
        tick();
        check("rm_c4", 32'(rsp_valid), 32'h0);

`ifdef BF16_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req_a[47:32] = 16'h3F80;
        req_b[47:32] = 16'h3F80;
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        repeat (7) tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        stat_sel  = 2'd2;
        #1;
        check("st_grants2", 32'(stat_grants), 32'd5);
        check("st_stalls", 32'(stat_stalls), 32'd3);
        stat_sel = 2'd0;
        #1;
        check("st_grants0", 32'(stat_grants), 32'd0);
        repeat (8) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
